tile_traversal_unit: RTL and testbench
======================================

Name: tile_traversal_unit

Overview:
- Initiator side of the edge-evaluation interface. Walks every T×T tile of a triangle's bounding box in raster order.
- Issues tile origins to the edge function evaluator, tags each issue with its coordinates, and collects the tile_inside verdicts.
- Forwards only covered tiles downstream through a small output FIFO with valid/ready handshake.
- Sits between triangle setup (bbox) and per-tile pixel rasterization.

Parameters:
- COORD_W, 10, tile/bbox coordinate width.
- T, 16, tile edge in pixels; power of two.
- EVAL_LAT, 2, cycles from eval_valid to the matching eval_tile_inside.
- OUT_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin traversal; sampled only when busy=0.
- bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y  in  COORD_W each  inclusive pixel bbox.
- busy  out  1  traversal in progress.
- done  out  1  one-cycle pulse when traversal finishes.
- eval_valid  out  1  tile issued to evaluator.
- eval_tile_x, eval_tile_y  out  COORD_W  issued tile origin.
- eval_tile_inside  in  1  verdict, valid EVAL_LAT cycles after eval_valid.
- out_valid  out  1  covered tile available.
- out_ready  in  1  downstream accepts.
- out_tile_x, out_tile_y  out  COORD_W  covered tile origin.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; FIFOs empty; delay line cleared.
- FSM states:
  - IDLE: start=1 → latch bbox. If min_x>max_x or min_y>max_y, go to DONE. Otherwise set cur_x = min_x & ~(T-1), cur_y = min_y & ~(T-1), go to WALK. start is ignored while busy.
  - WALK: issue one tile per cycle when credit is available.
  - DRAIN: wait for the delay line and the output FIFO to empty.
  - DONE: done=1 for 1 cycle, then IDLE.
- busy=1 in WALK, DRAIN and DONE. First eval_valid is the cycle after start is sampled.
- Credit rule: issue only when in_flight + out_count < OUT_DEPTH. in_flight is the number of set bits in the EVAL_LAT-deep valid delay line. This guarantees the output FIFO never overflows. eval_valid=0 when credit is exhausted.
- Issue order: x advances by T. After issuing x with x+T > max_x, or when x+T overflows COORD_W, x resets to the row start and y advances by T. The same end and overflow rule applies to y; after the last tile, go to DRAIN. Coordinates never wrap to 0.
- Tagging: each issued (x,y) is shifted into a coordinate delay line alongside its valid bit. When a valid bit emerges after EVAL_LAT cycles, sample eval_tile_inside. If it is 1, push the tagged (x,y) into the output FIFO. No ready is driven toward the evaluator; it never stalls.
- Output FIFO: out_valid = !empty. Pop when out_valid && out_ready. A simultaneous push and pop is allowed, and count is unchanged.
- DRAIN → DONE when in_flight=0 and the FIFO is empty, so all covered tiles have been delivered.
- Reset mid-traversal: everything clears immediately. Verdicts still in flight are discarded.

Optional Feature:
- Macro TILE_TRAV_STATS_EN.
- When defined: adds outputs stat_tested (16 bits) and stat_covered (16 bits). They are cleared on start and count issued tiles and pushed tiles respectively; both saturate at 0xFFFF and hold after done.
- When undefined: the ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package raster_pkg: the FSM state enum {IDLE, WALK, DRAIN, DONE}, the default T and COORD_W constants, and a tile_coord_t struct {x, y}.
- One natural sub-module: tile_coord_fifo, a parameterized sync FIFO of tile_coord_t with count output, used for the output buffer.

Test Plan (T=16, COORD_W=10, EVAL_LAT=2, OUT_DEPTH=4, tile_inside driven by a bench model):
- bbox (0,0)-(15,15), inside=1, out_ready=1 → exactly 1 eval_valid at (0,0); out (0,0); done pulses once; busy drops the cycle after done.
- bbox (5,20)-(40,33), all inside → issue order (0,16),(16,16),(32,16),(0,32),(16,32),(32,32); the same 6 appear on out in order.
- Same bbox, inside=1 only for x=16 → out exactly (16,16),(16,32); stat_covered=2, stat_tested=6 under TILE_TRAV_STATS_EN.
- bbox (0,0)-(127,15), all inside, out_ready=0 → eval_valid stops after 4 issues; raising out_ready resumes issue; all 8 tiles delivered in order, none lost or duplicated.
- bbox (1008,0)-(1023,0) → exactly one tile (1008,0); no issue at x=0. bbox min_x=50 > max_x=40 → no eval_valid; done 2 cycles after start.
- rst low during WALK with 2 tiles in flight → all outputs 0 the same cycle. After release with start=0: no out_valid and no done.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster types: traversal FSM states, default tile geometry and the
// tile coordinate pair carried from the evaluator tag line to the output FIFO.
package raster_pkg;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_T       = 16;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DRAIN,
        DONE
    } trav_state_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
    } tile_coord_t;

endpackage

// File: rtl/tile_coord_fifo.sv
// Small synchronous FIFO of tile coordinates with an occupancy count.
// DEPTH must be a power of two; pointers wrap naturally.
module tile_coord_fifo
    import raster_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  tile_coord_t              push_data,
    input  logic                     pop,
    output tile_coord_t              pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    tile_coord_t   mem [DEPTH];
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage and pointers; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tile_traversal_unit.sv
// Walks the T x T tiles of a bbox in raster order, issues each tile origin to
// the edge evaluator, tags it through an EVAL_LAT delay line, and forwards the
// covered tiles through an output FIFO. Issue is credit-limited so the FIFO
// can never overflow.
// Optional macro TILE_TRAV_STATS_EN adds stat_tested / stat_covered counters.
//
// state | meaning
// IDLE  | waiting for start (first tile is issued on the accepting edge)
// WALK  | issuing one tile per cycle while credit is available
// DRAIN | all tiles issued; waiting for verdicts and output FIFO to empty
// DONE  | one cycle before the done pulse; returns to IDLE
module tile_traversal_unit
    import raster_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int T         = DEF_T,
    parameter int EVAL_LAT  = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] bbox_min_x,
    input  logic [COORD_W-1:0] bbox_min_y,
    input  logic [COORD_W-1:0] bbox_max_x,
    input  logic [COORD_W-1:0] bbox_max_y,
    output logic               busy,
    output logic               done,
`ifdef TILE_TRAV_STATS_EN
    output logic [15:0]        stat_tested,
    output logic [15:0]        stat_covered,
`endif
    output logic               eval_valid,
    output logic [COORD_W-1:0] eval_tile_x,
    output logic [COORD_W-1:0] eval_tile_y,
    input  logic               eval_tile_inside,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_tile_x,
    output logic [COORD_W-1:0] out_tile_y
);

    localparam int CW = $clog2(OUT_DEPTH);
    localparam logic [COORD_W-1:0] ALIGN_MASK = ~COORD_W'(T - 1);

    trav_state_t        state;
    logic [COORD_W-1:0] cur_x, cur_y, row_x_q, max_x_q, max_y_q;
    logic [EVAL_LAT-1:0] vld_dl;
    logic [COORD_W-1:0] dl_x [EVAL_LAT];
    logic [COORD_W-1:0] dl_y [EVAL_LAT];

    logic [COORD_W-1:0] iss_x, iss_y, lim_x, lim_y, row_x;
    logic [COORD_W:0]   nx, ny;
    logic               x_end, y_end, bbox_empty, accept, credit, issue;
    logic [7:0]         in_flight;
    logic [CW:0]        fifo_count;
    logic               fifo_empty, push;
    tile_coord_t        push_data, pop_data;

    // Source of the next tile: the live bbox on the accepting edge, else the walk registers.
    always_comb begin
        if (state == IDLE) begin
            iss_x = bbox_min_x & ALIGN_MASK;
            iss_y = bbox_min_y & ALIGN_MASK;
            lim_x = bbox_max_x;
            lim_y = bbox_max_y;
            row_x = bbox_min_x & ALIGN_MASK;
        end else begin
            iss_x = cur_x;
            iss_y = cur_y;
            lim_x = max_x_q;
            lim_y = max_y_q;
            row_x = row_x_q;
        end
        // One extra bit so stepping past the top of the coordinate range ends the row/column.
        nx    = {1'b0, iss_x} + (COORD_W+1)'(T);
        ny    = {1'b0, iss_y} + (COORD_W+1)'(T);
        x_end = nx > {1'b0, lim_x};
        y_end = ny > {1'b0, lim_y};
    end

    // Outstanding verdicts: the tile on the evaluator port plus every tagged stage.
    always_comb begin
        in_flight = 8'(eval_valid);
        for (int i = 0; i < EVAL_LAT; i++) begin
            in_flight = in_flight + 8'(vld_dl[i]);
        end
    end

    assign bbox_empty = (bbox_min_x > bbox_max_x) || (bbox_min_y > bbox_max_y);
    assign accept     = (state == IDLE) && start && !busy;
    // Pops are ignored, so credit is conservative and never lets the FIFO overflow.
    assign credit     = (9'(in_flight) + 9'(fifo_count)) < 9'(OUT_DEPTH);
    // Pipeline is empty whenever IDLE accepts start, so the first tile needs no credit check.
    assign issue      = (accept && !bbox_empty) || ((state == WALK) && credit);

    assign push        = vld_dl[EVAL_LAT-1] && eval_tile_inside;
    assign push_data.x = dl_x[EVAL_LAT-1];
    assign push_data.y = dl_y[EVAL_LAT-1];

    // Traversal FSM with registered busy/done/eval outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            eval_valid  <= 1'b0;
            eval_tile_x <= '0;
            eval_tile_y <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            row_x_q     <= '0;
            max_x_q     <= '0;
            max_y_q     <= '0;
        end else begin
            done       <= 1'b0;
            eval_valid <= issue;
            if (issue) begin
                eval_tile_x <= iss_x;
                eval_tile_y <= iss_y;
                if (!x_end) begin
                    cur_x <= nx[COORD_W-1:0];
                    cur_y <= iss_y;
                end else if (!y_end) begin
                    cur_x <= row_x;
                    cur_y <= ny[COORD_W-1:0];
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        row_x_q <= row_x;
                        max_x_q <= bbox_max_x;
                        max_y_q <= bbox_max_y;
                        if (bbox_empty)
                            state <= DONE;
                        else if (x_end && y_end)
                            state <= DRAIN;
                        else
                            state <= WALK;
                    end else begin
                        // busy is held through the done cycle and released here.
                        busy <= 1'b0;
                    end
                end
                WALK: begin
                    if (issue && x_end && y_end)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (in_flight == 8'd0 && fifo_empty)
                        state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag line: valid bit and coordinates travel together for EVAL_LAT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_dl <= '0;
            for (int i = 0; i < EVAL_LAT; i++) begin
                dl_x[i] <= '0;
                dl_y[i] <= '0;
            end
        end else begin
            vld_dl[0] <= eval_valid;
            dl_x[0]   <= eval_tile_x;
            dl_y[0]   <= eval_tile_y;
            for (int i = 1; i < EVAL_LAT; i++) begin
                vld_dl[i] <= vld_dl[i-1];
                dl_x[i]   <= dl_x[i-1];
                dl_y[i]   <= dl_y[i-1];
            end
        end
    end

`ifdef TILE_TRAV_STATS_EN
    // Saturating per-traversal counters, cleared when a new start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_tested  <= '0;
            stat_covered <= '0;
        end else if (accept) begin
            stat_tested  <= '0;
            stat_covered <= '0;
        end else begin
            if (eval_valid && stat_tested != 16'hFFFF)
                stat_tested <= stat_tested + 16'd1;
            if (push && stat_covered != 16'hFFFF)
                stat_covered <= stat_covered + 16'd1;
        end
    end
`endif

    tile_coord_fifo #(
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (out_valid && out_ready),
        .pop_data (pop_data),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_tile_x = pop_data.x;
    assign out_tile_y = pop_data.y;

endmodule

// File: tb/tb_tile_traversal_unit.sv
`timescale 1ns/1ps
module tb_tile_traversal_unit;

    localparam int TT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bbox_min_x = '0, bbox_min_y = '0, bbox_max_x = '0, bbox_max_y = '0;
    logic       busy, done, eval_valid, out_valid;
    logic [9:0] eval_tile_x, eval_tile_y, out_tile_x, out_tile_y;
    logic       eval_tile_inside = 1'b0;
    logic       out_ready = 1'b0;
`ifdef TILE_TRAV_STATS_EN
    logic [15:0] stat_tested, stat_covered;
`endif

    tile_traversal_unit #(
        .COORD_W(10), .T(16), .EVAL_LAT(2), .OUT_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .bbox_min_x(bbox_min_x), .bbox_min_y(bbox_min_y),
        .bbox_max_x(bbox_max_x), .bbox_max_y(bbox_max_y),
        .busy(busy), .done(done),
`ifdef TILE_TRAV_STATS_EN
        .stat_tested(stat_tested), .stat_covered(stat_covered),
`endif
        .eval_valid(eval_valid), .eval_tile_x(eval_tile_x), .eval_tile_y(eval_tile_y),
        .eval_tile_inside(eval_tile_inside),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tile_x(out_tile_x), .out_tile_y(out_tile_y)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; } pt_t;
    typedef struct {
        int minx; int miny; int maxx; int maxy;
        int imode; int rmode; int exp_issue; int exp_out;
    } vec_t;

    int   errors = 0, checks = 0;
    int   cyc = 0;
    int   inside_mode = 0, ready_mode = 0, seed = 0;
    pt_t  iss_q[$], out_q[$], exp_iss[$], exp_out[$];
    int   done_cnt = 0, done_cyc = -1, start_cyc = -1, first_eval_cyc = -1;
    int   busy_at_done = -1, busy_after_done = -1, outv_seen = 0;
    int   hv[3], hx[3], hy[3];

    function automatic bit inside_fn(int x, int y);
        case (inside_mode)
            0:       return 1'b1;
            1:       return (x == 16);
            default: return (((x / TT) * 7 + (y / TT) * 3 + seed) % 3) != 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: enumerate aligned tiles row by row, stopping at bbox max or coordinate range end.
    task automatic build_expected(input int minx, input int miny, input int maxx, input int maxy);
        exp_iss.delete();
        exp_out.delete();
        if (minx > maxx || miny > maxy) return;
        for (int y = miny - (miny % TT); y <= maxy && y < 1024; y += TT)
            for (int x = minx - (minx % TT); x <= maxx && x < 1024; x += TT) begin
                exp_iss.push_back('{x, y});
                if (inside_fn(x, y)) exp_out.push_back('{x, y});
            end
    endtask

    // Monitor / responder: samples at the falling edge, drives ready and verdicts.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (start) start_cyc = cyc;
        if (eval_valid) begin
            if (first_eval_cyc < 0) first_eval_cyc = cyc;
            iss_q.push_back('{int'(eval_tile_x), int'(eval_tile_y)});
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
        end
        if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = int'(busy);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(1, 0));
        endcase
        if (out_valid) outv_seen++;
        if (out_valid && out_ready && rst) out_q.push_back('{int'(out_tile_x), int'(out_tile_y)});
        hv[2] = hv[1]; hx[2] = hx[1]; hy[2] = hy[1];
        hv[1] = hv[0]; hx[1] = hx[0]; hy[1] = hy[0];
        hv[0] = int'(eval_valid); hx[0] = int'(eval_tile_x); hy[0] = int'(eval_tile_y);
        eval_tile_inside = (hv[2] != 0) ? inside_fn(hx[2], hy[2]) : 1'($urandom_range(1, 0));
    end

    task automatic begin_bbox(input int minx, input int miny, input int maxx, input int maxy);
        build_expected(minx, miny, maxx, maxy);
        @(posedge clk); #2;
        iss_q.delete(); out_q.delete();
        done_cnt = 0; done_cyc = -1; first_eval_cyc = -1;
        busy_at_done = -1; busy_after_done = -1;
        bbox_min_x = 10'(minx); bbox_min_y = 10'(miny);
        bbox_max_x = 10'(maxx); bbox_max_y = 10'(maxy);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic finish_bbox(input string tag);
        int n_bad;
        int i;
        for (i = 0; i < 5000 && !(done_cnt > 0 && busy_after_done >= 0); i++) @(posedge clk);
        if (i >= 5000) chk({tag, "_timeout"}, 1, 0);
        repeat (3) @(posedge clk);
        #2;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_at_done"}, busy_at_done, 1);
        chk({tag, "_busy_after_done"}, busy_after_done, 0);
        chk({tag, "_issue_count"}, iss_q.size(), exp_iss.size());
        chk({tag, "_out_count"}, out_q.size(), exp_out.size());
        n_bad = 0;
        for (int k = 0; k < iss_q.size() && k < exp_iss.size(); k++)
            if (iss_q[k] != exp_iss[k]) n_bad++;
        chk({tag, "_issue_order"}, n_bad, 0);
        n_bad = 0;
        for (int k = 0; k < out_q.size() && k < exp_out.size(); k++)
            if (out_q[k] != exp_out[k]) n_bad++;
        chk({tag, "_out_order"}, n_bad, 0);
        if (exp_iss.size() > 0)
            chk({tag, "_first_issue_latency"}, first_eval_cyc - start_cyc, 1);
        else
            chk({tag, "_empty_done_latency"}, done_cyc - start_cyc, 2);
`ifdef TILE_TRAV_STATS_EN
        chk({tag, "_stat_tested"}, int'(stat_tested), exp_iss.size());
        chk({tag, "_stat_covered"}, int'(stat_covered), exp_out.size());
`endif
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0,    0,    15,   15,   0, 0, 1,   1};
        vecs[1] = '{5,    20,   40,   33,   0, 0, 6,   6};
        vecs[2] = '{5,    20,   40,   33,   1, 0, 6,   2};
        vecs[3] = '{1008, 0,    1023, 0,    0, 0, 1,   1};
        vecs[4] = '{50,   0,    40,   10,   0, 0, 0,   0};
        vecs[5] = '{0,    1000, 1023, 1023, 2, 2, 128, -1};
        vecs[6] = '{1000, 1010, 1023, 1023, 0, 2, 2,   2};

        // Reset state.
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_eval_valid", int'(eval_valid), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            inside_mode = vecs[v].imode;
            ready_mode  = vecs[v].rmode;
            seed        = 5;
            begin_bbox(vecs[v].minx, vecs[v].miny, vecs[v].maxx, vecs[v].maxy);
            finish_bbox(tag);
            chk({tag, "_table_issue"}, iss_q.size(), vecs[v].exp_issue);
            if (vecs[v].exp_out >= 0) chk({tag, "_table_out"}, out_q.size(), vecs[v].exp_out);
        end

        // Backpressure: with downstream stalled, issue must stop at the FIFO depth.
        inside_mode = 0;
        ready_mode  = 1;
        begin_bbox(0, 0, 127, 15);
        repeat (20) @(posedge clk);
        #2;
        chk("stall_issue_count", iss_q.size(), 4);
        chk("stall_eval_valid", int'(eval_valid), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        ready_mode = 0;
        finish_bbox("stall");

        // Randomized bboxes with random coverage and random backpressure.
        for (int r = 0; r < 12; r++) begin
            int minx, miny, maxx, maxy;
            inside_mode = 2;
            ready_mode  = 2;
            seed = int'($urandom_range(99, 0));
            minx = int'($urandom_range(1023, 0));
            miny = int'($urandom_range(1023, 0));
            maxx = minx + int'($urandom_range(70, 0)) - 6;
            maxy = miny + int'($urandom_range(70, 0)) - 6;
            if (maxx > 1023) maxx = 1023;
            if (maxy > 1023) maxy = 1023;
            if (maxx < 0) maxx = 0;
            if (maxy < 0) maxy = 0;
            begin_bbox(minx, miny, maxx, maxy);
            finish_bbox($sformatf("rand%0d", r));
        end

        // Reset mid-walk with tiles in flight.
        inside_mode = 0;
        ready_mode  = 1;
        begin_bbox(0, 0, 127, 127);
        for (int i = 0; i < 50 && iss_q.size() < 2; i++) begin
            @(posedge clk); #2;
        end
        chk("midrst_reached_walk", int'(iss_q.size() >= 2), 1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_eval_valid", int'(eval_valid), 0);
        chk("midrst_eval_xy", int'(eval_tile_x) + int'(eval_tile_y), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_xy", int'(out_tile_x) + int'(out_tile_y), 0);
`ifdef TILE_TRAV_STATS_EN
        chk("midrst_stats", int'(stat_tested) + int'(stat_covered), 0);
`endif
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        outv_seen = 0;
        done_cnt = 0;
        ready_mode = 0;
        repeat (12) @(posedge clk);
        #2;
        chk("postrst_out_valid_seen", outv_seen, 0);
        chk("postrst_done_seen", done_cnt, 0);
        chk("postrst_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
